mprj_mem_responder: RTL

User-project-side responder for the 64x8 memory GPIO protocol on the Caravel `mprj_io` pins. It synchronizes host-driven read/write enables, a 6-bit address and an 8-bit data bus arriving from the pads, and qualifies each command by stability. It executes writes into an internal 64x8 register array and drives read data back onto the shared data pins with active-low output enables. It sits between the `mprj_io` pad signals and the memory storage inside the user project wrapper.

---
 rtl/mprj_mem_responder_if.sv | 41 ++++
 rtl/mprj_mem_responder.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/mprj_mem_responder_if.sv
// Pad-side bundle between the mprj_io pins and the 64x8 memory responder.
// Defining MEM_PARITY_EN adds the sticky parity_err_o line.
interface mprj_mem_responder_if #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 8
);
  logic              wr_en_i;
  logic              rd_en_i;
  logic [ADDR_W-1:0] addr_i;
  logic [DATA_W-1:0] data_i;
  logic [DATA_W-1:0] data_o;
  logic [DATA_W-1:0] data_oeb;
  logic              rd_valid_o;
  logic              busy_o;
  logic              cmd_err_o;
`ifdef MEM_PARITY_EN
  logic              parity_err_o;

  modport master (
    output wr_en_i, rd_en_i, addr_i, data_i,
    input  data_o, data_oeb, rd_valid_o,
    input  busy_o, cmd_err_o, parity_err_o
  );
  modport slave (
    input  wr_en_i, rd_en_i, addr_i, data_i,
    output data_o, data_oeb, rd_valid_o,
    output busy_o, cmd_err_o, parity_err_o
  );
`else
  modport master (
    output wr_en_i, rd_en_i, addr_i, data_i,
    input  data_o, data_oeb, rd_valid_o,
    input  busy_o, cmd_err_o
  );
  modport slave (
    input  wr_en_i, rd_en_i, addr_i, data_i,
    output data_o, data_oeb, rd_valid_o,
    output busy_o, cmd_err_o
  );
`endif
endinterface

// File: rtl/mprj_mem_responder.sv
// 64x8 GPIO memory responder: syncs pad commands, qualifies by stability.
// Optional MEM_PARITY_EN stores an even-parity bit per word.
module mprj_mem_responder #(
  parameter int ADDR_W     = 6,
  parameter int DATA_W     = 8,
  parameter int STABLE_CYC = 4
) (
  input logic wb_clk_i,
  input logic wb_rst_i,
  mprj_mem_responder_if.slave bus
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam int TW = 2 + ADDR_W + DATA_W;
  localparam logic [3:0] SC = 4'(STABLE_CYC);

  typedef enum logic [1:0] {
    IDLE, WRITE, READ, RDHOLD
  } state_t;

  state_t state, state_n;

  logic              wr_m, rd_m, wr_s, rd_s;
  logic [ADDR_W-1:0] addr_m, addr_s;
  logic [DATA_W-1:0] data_m, data_s;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      wr_m   <= 1'b0;
      rd_m   <= 1'b0;
      addr_m <= '0;
      data_m <= '0;
      wr_s   <= 1'b0;
      rd_s   <= 1'b0;
      addr_s <= '0;
      data_s <= '0;
    end else begin
      wr_m   <= bus.wr_en_i;
      rd_m   <= bus.rd_en_i;
      addr_m <= bus.addr_i;
      data_m <= bus.data_i;
      wr_s   <= wr_m;
      rd_s   <= rd_m;
      addr_s <= addr_m;
      data_s <= data_m;
    end
  end

  // Read tuples mask data: those pins may be driven by this block.
  function automatic logic [TW-1:0] tuple(
    input logic              w,
    input logic              r,
    input logic [ADDR_W-1:0] a,
    input logic [DATA_W-1:0] d
  );
    return {w, r, a, (r && !w) ? {DATA_W{1'b0}} : d};
  endfunction

  logic [TW-1:0] t_cur, t_nxt, last;
  logic [3:0]    cnt;
  logic          both, one_en, qual, take;

  assign t_cur  = tuple(wr_s, rd_s, addr_s, data_s);
  assign t_nxt  = tuple(wr_m, rd_m, addr_m, data_m);
  assign both   = wr_s & rd_s;
  assign one_en = wr_s ^ rd_s;
  assign qual   = (cnt == SC) && one_en && (t_cur != last);

  // cnt = cycles the synced tuple has held, counting the current one.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i)
      cnt <= '0;
    else if (t_nxt != t_cur)
      cnt <= 4'd1;
    else if (cnt != SC)
      cnt <= cnt + 4'd1;
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i)
      last <= '0;
    else if (!wr_s && !rd_s)
      last <= '0;
    else if (take)
      last <= t_cur;
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i)
      state <= IDLE;
    else
      state <= state_n;
  end

  always_comb begin
    state_n = state;
    take    = 1'b0;
    unique case (state)
      IDLE: begin
        if (qual) begin
          take    = 1'b1;
          state_n = wr_s ? WRITE : READ;
        end
      end
      WRITE: state_n = IDLE;
      READ:  state_n = both ? IDLE : RDHOLD;
      RDHOLD: begin
        if (!rd_s || wr_s) begin
          state_n = IDLE;
        end else if (qual) begin
          take    = 1'b1;
          state_n = READ;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= '0;
    end else if (state == WRITE) begin
      mem[addr_s] <= data_s;
    end
  end

  logic [DATA_W-1:0] data_q;
  logic              valid_q;
  logic              err_q;

  // Bus is held only while RDHOLD persists; leaving it releases next edge.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      valid_q <= (state == RDHOLD) && (state_n == RDHOLD);
      if (state == READ)
        data_q <= mem[addr_s];
      else if (state_n == IDLE)
        data_q <= '0;
      if (both)
        err_q <= 1'b1;
    end
  end

`ifdef MEM_PARITY_EN
  logic par [DEPTH];
  logic perr_q;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      for (int i = 0; i < DEPTH; i++)
        par[i] <= 1'b0;
      perr_q <= 1'b0;
    end else begin
      if (state == WRITE)
        par[addr_s] <= ^data_s;
      if (state == READ && ((^mem[addr_s]) != par[addr_s]))
        perr_q <= 1'b1;
    end
  end

  assign bus.parity_err_o = perr_q;
`endif

  assign bus.data_o     = data_q;
  assign bus.data_oeb   = {DATA_W{~valid_q}};
  assign bus.rd_valid_o = valid_q;
  assign bus.busy_o     = (state == WRITE) || (state == READ);
  assign bus.cmd_err_o  = err_q;

endmodule
